// File: rtl/linebuffer_3x3_ctrl.sv
// Frame sequencer for the 3x3 line-buffer window generator: one pixel request per
// cycle per frame, with raster tags that flag the cycles holding an interior window.
module linebuffer_3x3_ctrl #(
  parameter int LEN1   = 16,
  parameter int LEN2   = 14,
  parameter int LEN3   = 28,
  parameter int LEN4   = 56,
  parameter int LEN5   = 112,
  parameter int LEN6   = 224,
  parameter int RD_LAT = 2,
  parameter int ROW_W  = 10,
  parameter int COL_W  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cfg_sel,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic             abort,
  output logic [2:0]       lb_sel,
  output logic             pix_req,
  output logic             busy,
  output logic             win_valid,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             done,
  output logic             cfg_err
);

  // state | meaning
  // IDLE  | waiting for an accepted start
  // RUN   | one pixel request per cycle, raster order
  // DRAIN | no requests; last tags still moving through the pipeline
  // FIN   | done pulse
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam int DEPTH = RD_LAT + 1;
  localparam int DW    = $clog2(RD_LAT + 2);

  function automatic logic [COL_W-1:0] last_col(input logic [2:0] sel);
    int w;
    w = LEN1;
    if (sel >= 3'd1) w += LEN2;
    if (sel >= 3'd2) w += LEN3;
    if (sel >= 3'd3) w += LEN4;
    if (sel >= 3'd4) w += LEN5;
    if (sel >= 3'd5) w += LEN6;
    return COL_W'(w - 1);
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic [COL_W-1:0] wlast_q, wlast_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             err_q, err_d;
  logic             push;
  logic             flush;

  logic [DEPTH-1:0] tv_q;
  logic [ROW_W-1:0] tr_q [DEPTH];
  logic [COL_W-1:0] tc_q [DEPTH];
  logic             tag_ok;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rows_d  = rows_q;
    wlast_d = wlast_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;
    err_d   = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_sel <= 3'd5 && cfg_rows >= ROW_W'(3)) begin
            sel_d   = cfg_sel;
            rows_d  = cfg_rows;
            wlast_d = last_col(cfg_sel);
            row_d   = '0;
            col_d   = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        push = 1'b1;
        if (col_q == wlast_q) begin
          col_d = '0;
          if (row_q == rows_q - ROW_W'(1)) begin
            drain_d = DW'(RD_LAT);
            state_d = DRAIN;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = FIN;
        else               drain_d = drain_q - DW'(1);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort overrides everything once a frame is under way
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rows_q  <= '0;
      wlast_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rows_q  <= rows_d;
      wlast_q <= wlast_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

  // Stage DEPTH-1 lines up with the pixel sitting in the bottom-right window register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tr_q[i] <= '0;
        tc_q[i] <= '0;
      end
    end else if (flush) begin
      tv_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tr_q[i] <= '0;
        tc_q[i] <= '0;
      end
    end else begin
      tv_q[0] <= push;
      tr_q[0] <= push ? row_q : '0;
      tc_q[0] <= push ? col_q : '0;
      for (int i = 1; i < DEPTH; i++) begin
        tv_q[i] <= tv_q[i-1];
        tr_q[i] <= tr_q[i-1];
        tc_q[i] <= tc_q[i-1];
      end
    end
  end

  assign tag_ok = tv_q[DEPTH-1] && (tr_q[DEPTH-1] >= ROW_W'(2)) && (tc_q[DEPTH-1] >= COL_W'(2));

  assign win_valid = tag_ok;
  assign win_row   = tag_ok ? tr_q[DEPTH-1] - ROW_W'(1) : '0;
  assign win_col   = tag_ok ? tc_q[DEPTH-1] - COL_W'(1) : '0;
  assign lb_sel    = sel_q;
  assign pix_req   = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_linebuffer_3x3_ctrl.sv
// Bench for linebuffer_3x3_ctrl: frame-level reference model feeds a window
// scoreboard and per-cycle control expectations.
module tb_linebuffer_3x3_ctrl;

  localparam int RD_LAT = 2;
  localparam int ROW_W  = 10;
  localparam int COL_W  = 9;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [2:0]       cfg_sel;
  logic [ROW_W-1:0] cfg_rows;
  logic [2:0]       lb_sel;
  logic             pix_req, busy, win_valid, done, cfg_err;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;

  linebuffer_3x3_ctrl #(.RD_LAT(RD_LAT), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_sel(cfg_sel), .cfg_rows(cfg_rows),
    .abort(abort), .lb_sel(lb_sel), .pix_req(pix_req), .busy(busy),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int r; int c;} win_t;
  win_t win_q[$];

  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int req_lo = 0, req_hi = -1, busy_hi = -1, done_cyc = -1, err_cyc = -1;
  int sel_cyc = 0;
  logic [2:0] prev_sel = 3'd0, cur_sel = 3'd0;
  int win_seen = 0, done_seen = 0, exp_wins = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int width_of(input int sel);
    int lens [6];
    int w;
    lens = '{16, 14, 28, 56, 112, 224};
    w = 0;
    for (int i = 0; i <= sel; i++) w += lens[i];
    return w;
  endfunction

  // Monitor: per-cycle control expectations plus the window scoreboard.
  logic        e_req, e_busy, e_done, e_err, e_v;
  logic [2:0]  e_sel;
  int          e_r, e_c;
  always @(negedge clk) begin
    e_req  = (cyc >= req_lo && cyc <= req_hi);
    e_busy = (cyc >= req_lo && cyc <= busy_hi);
    e_done = (cyc == done_cyc);
    e_err  = (cyc == err_cyc);
    e_sel  = (cyc >= sel_cyc) ? cur_sel : prev_sel;
    n_tests++;
    if ({pix_req, busy, done, cfg_err, lb_sel} !== {e_req, e_busy, e_done, e_err, e_sel}) begin
      n_fail++;
      $display("FAIL ctl cyc=%0d req/busy/done/err/sel got=%b%b%b%b/%0d exp=%b%b%b%b/%0d",
               cyc, pix_req, busy, done, cfg_err, lb_sel, e_req, e_busy, e_done, e_err, e_sel);
    end
    e_v = 1'b0; e_r = 0; e_c = 0;
    if (win_q.size() > 0 && win_q[0].cyc == cyc) begin
      e_v = 1'b1; e_r = win_q[0].r; e_c = win_q[0].c;
      void'(win_q.pop_front());
    end
    n_tests++;
    if ({win_valid, win_row, win_col} !== {e_v, ROW_W'(e_r), COL_W'(e_c)}) begin
      n_fail++;
      $display("FAIL win cyc=%0d got v=%b r=%0d c=%0d exp v=%b r=%0d c=%0d",
               cyc, win_valid, win_row, win_col, e_v, e_r, e_c);
    end
    if (win_valid) win_seen++;
    if (done) done_seen++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input int sel, input int rows);
    int s, w, n;
    bit act, ok;
    cfg_sel = 3'(sel); cfg_rows = ROW_W'(rows); start = 1'b1;
    s   = cyc;
    act = (s >= req_lo && s <= busy_hi);
    ok  = (sel <= 5) && (rows >= 3);
    if (!act) begin
      if (!ok) err_cyc = s + 1;
      else begin
        w = width_of(sel); n = rows * w;
        req_lo = s + 1; req_hi = s + n;
        busy_hi = s + n + RD_LAT + 2; done_cyc = busy_hi;
        prev_sel = cur_sel; cur_sel = 3'(sel); sel_cyc = s + 1;
        for (int k = 0; k < n; k++)
          if (k / w >= 2 && k % w >= 2)
            win_q.push_back('{s + k + RD_LAT + 2, k / w - 1, k % w - 1});
        exp_wins = (rows - 2) * (w - 2);
        win_seen = 0; done_seen = 0;
      end
    end
    step();
    start = 1'b0;
  endtask

  task automatic finish_frame();
    while (cyc <= busy_hi) step();
    step();
    if (exp_wins >= 0) begin
      n_tests++;
      if (win_seen != exp_wins) begin
        n_fail++;
        $display("FAIL win_count got=%0d exp=%0d", win_seen, exp_wins);
      end
      n_tests++;
      if (done_seen != 1) begin
        n_fail++;
        $display("FAIL done_count got=%0d exp=1", done_seen);
      end
    end
    exp_wins = -1;
  endtask

  task automatic abort_now();
    int a;
    a = cyc; abort = 1'b1;
    if (a >= req_lo && a <= busy_hi) begin
      if (req_hi > a) req_hi = a;
      busy_hi = a; done_cyc = -1; exp_wins = -1; done_seen = 0;
      while (win_q.size() > 0 && win_q[$].cyc > a) void'(win_q.pop_back());
    end
    step();
    abort = 1'b0;
  endtask

  task automatic check_no_done(input string name);
    n_tests++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL %s done_count got=%0d exp=0", name, done_seen);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_lo = 0; req_hi = -1; busy_hi = -1; done_cyc = -1; err_cyc = -1;
    prev_sel = 3'd0; cur_sel = 3'd0; sel_cyc = 0; exp_wins = -1;
    win_q.delete();
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, sel, rows, off;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_sel = 3'd0; cfg_rows = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // reset mid-frame, then a clean frame
    start_frame(2, 5);
    repeat (30) step();
    do_reset();
    start_frame(2, 5);
    finish_frame();

    // reference frame, then back-to-back start on the cycle after done
    start_frame(0, 4);
    while (cyc <= busy_hi) step();
    start_frame(0, 4);
    finish_frame();

    // widest line
    start_frame(5, 3);
    finish_frame();

    // rejected configs
    start_frame(6, 5);
    repeat (3) step();
    start_frame(1, 2);
    repeat (3) step();

    // abort while idle coincident with start: start wins
    abort = 1'b1;
    start_frame(0, 3);
    abort = 1'b0;
    finish_frame();

    // start while busy is ignored, then abort on cycle 20
    s0 = cyc;
    start_frame(1, 4);
    while (cyc < s0 + 10) step();
    start_frame(2, 4);
    while (cyc < s0 + 20) step();
    abort_now();
    repeat (8) step();
    check_no_done("abort");
    start_frame(1, 4);
    finish_frame();

    // randomized frames, aborts and bad configs
    for (int it = 0; it < 12; it++) begin
      off  = int'($urandom_range(0, 4));
      sel  = (off == 4) ? 6 : off;
      rows = int'($urandom_range(2, 6));
      start_frame(sel, rows);
      if (sel <= 5 && rows >= 3) begin
        if ($urandom_range(0, 3) == 0) begin
          off = int'($urandom_range(1, rows * width_of(sel)));
          while (cyc < req_lo - 1 + off) step();
          abort_now();
          repeat (6) step();
          check_no_done("rand_abort");
        end else begin
          finish_frame();
        end
      end else begin
        repeat (3) step();
      end
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (4) step();
    n_tests++;
    if (win_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_windows got=%0d exp=0", win_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/linebuffer_3x3_ctrl.md
Name: linebuffer_3x3_ctrl

Overview:
Frame sequencer for the 6-size 3x3 line-buffer window generator. Latches a size select and row count on start, holds the line-buffer tap select stable, and issues one pixel request per cycle for the whole frame, with no gaps. The line buffer has no enable. The block tracks raster coordinates through the pixel-source latency and the window register stage, so it flags exactly the cycles on which the 72-bit window holds a fully interior 3x3 neighbourhood. It then pulses done.

Parameters:
LEN1, 16, line-buffer segment 1 depth
LEN2, 14, segment 2 depth
LEN3, 28, segment 3 depth
LEN4, 56, segment 4 depth
LEN5, 112, segment 5 depth
LEN6, 224, segment 6 depth
RD_LAT, 2, cycles from pix_req to pixel valid on the line-buffer stream input (>=0)
ROW_W, 10, width of row count and row coordinates
COL_W, 9, width of column coordinates (must hold LEN1+...+LEN6-1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle frame start request
cfg_sel  in  3  size select, sampled with start
cfg_rows  in  ROW_W  frame height in lines, sampled with start
abort  in  1  synchronous frame abort
lb_sel  out  3  tap select to the line buffer
pix_req  out  1  request one pixel from the feeder this cycle
busy  out  1  frame in progress
win_valid  out  1  line-buffer window output is a valid interior window this cycle
win_row  out  ROW_W  window centre row (valid with win_valid)
win_col  out  COL_W  window centre column (valid with win_valid)
done  out  1  single-cycle frame completion pulse
cfg_err  out  1  single-cycle pulse: start rejected

Behaviour:
- Reset: all outputs 0; state IDLE; lb_sel=0; all counters and pipeline tags cleared. rst asserted mid-frame aborts immediately; no done is produced.
- Line width W(sel) = LEN1+...+LEN(sel+1), giving 16, 30, 58, 114, 226, 450 at defaults.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start with cfg_sel<=5 and cfg_rows>=3: latch the config, drive lb_sel=cfg_sel from the next cycle, go to RUN.
  - start with cfg_sel>=6 or cfg_rows<3: cfg_err=1 for one cycle, stay in IDLE, lb_sel unchanged.
- start while busy: ignored, no cfg_err.
- RUN:
  - pix_req=1 every cycle for exactly N=rows*W cycles, with no bubbles.
  - Request coordinates (r,c) advance in raster order: c wraps W-1 to 0 and increments r.
  - After the request for (rows-1, W-1), go to DRAIN.
- Tag pipeline: each request pushes {1,r,c} into a shift pipeline of depth RD_LAT+1. Idle cycles push {0,..}. The pipeline output is aligned to the cycle when that pixel sits in the bottom-right window register.
- win_valid = tag_valid && tag_r>=2 && tag_c>=2.
- win_row = tag_r-1 and win_col = tag_c-1 when win_valid; both are 0 otherwise.
- DRAIN: pix_req=0. Lasts RD_LAT+1 cycles, until the last tag exits, then go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- busy=1 from the first RUN cycle through the FIN cycle inclusive.
- Timing, with start sampled at cycle 0:
  - pix_req high on cycles 1..N.
  - Pixel k (raster index) gives a window on cycle k+RD_LAT+2.
  - done fires on cycle N+RD_LAT+2.
- lb_sel is held constant for the whole frame and keeps its value in IDLE until the next accepted start.
- abort (any non-IDLE state): next cycle is IDLE, pix_req=0, the tag pipeline is flushed (win_valid=0), no done. abort and start in the same cycle while IDLE: start takes effect.
- Window count per frame = (rows-2)*(W-2). No window is produced for the first two columns or first two rows, including across line wrap.
- Counter arithmetic is unsigned. No coordinate exceeds W-1 or rows-1.

Test Plan:
- rst=1 during RUN (sel=2, rows=5), release -> all outputs 0, IDLE. A new start then runs a complete frame normally.
- RD_LAT=2, start sel=0 rows=4 at cycle 0:
  - pix_req on cycles 1..64.
  - 28 win_valid pulses; first on cycle 38 with centre (1,1), last on cycle 67 with centre (2,14).
  - done on cycle 68; busy high on cycles 1..68.
- sel=5 rows=3 -> N=1350 and 448 windows.
  - Centre col sequence 1..448 per valid row, then the 2-cycle gap at each line wrap.
  - lb_sel=5 held throughout.
- start with cfg_sel=6, then cfg_rows=2 -> cfg_err pulse each time, busy stays 0, lb_sel unchanged.
- start asserted mid-frame, then abort on cycle 20 of a sel=1 rows=4 frame:
  - The start is ignored.
  - The abort gives pix_req=0 and win_valid=0 from cycle 21, and no done.
  - A following start runs a full frame normally.
- Back-to-back: start on the cycle after done -> second frame accepted, request timing identical to the first frame.
